// File: rtl/counter_snapshot_fifo_pkg.sv
// Shared defaults and helpers for the counter snapshot FIFO.
package counter_snap_pkg;

    localparam int SNAP_N     = 12;
    localparam int SNAP_DEPTH = 4;
    localparam int SNAP_WRAPW = 8;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/counter_snapshot_fifo_if.sv
// Valid/ready drain port of the snapshot FIFO.
interface counter_snapshot_fifo_if
    import counter_snap_pkg::*;
#(
    parameter int N     = SNAP_N,
    parameter int DEPTH = SNAP_DEPTH
);
    localparam int CW = ptr_w(DEPTH) + 1;

    logic          snap_valid;
    logic          snap_ready;
    logic [N-1:0]  snap_data;
    logic [CW-1:0] snap_count;

    modport master (
        output snap_valid,
        output snap_data,
        output snap_count,
        input  snap_ready
    );

    modport slave (
        input  snap_valid,
        input  snap_data,
        input  snap_count,
        output snap_ready
    );

endinterface

// File: rtl/counter_snapshot_fifo_snap_fifo.sv
// Synchronous first-word-fall-through FIFO; storage is not reset.
module snap_fifo
    import counter_snap_pkg::*;
#(
    parameter  int W     = SNAP_N,
    parameter  int DEPTH = SNAP_DEPTH,
    localparam int PW    = ptr_w(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PW'(1);
            if (pop_i)  rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/counter_snapshot_fifo.sv
// Counter snapshot FIFO with wrap counting; define SNAP_DELTA_EN to store
// deltas between accepted captures instead of absolute counts.
module counter_snapshot_fifo
    import counter_snap_pkg::*;
#(
    parameter int n     = SNAP_N,
    parameter int DEPTH = SNAP_DEPTH,
    parameter int WRAPW = SNAP_WRAPW
) (
    input  logic                      clk,
    input  logic                      rst_counter,
    input  logic [n-1:0]              q_counter,
    input  logic                      capture,
    counter_snapshot_fifo_if.master   snap,
    output logic                      overflow,
    output logic [WRAPW-1:0]          wrap_count
);

    logic [n-1:0]     q_prev_q;
    logic [WRAPW-1:0] wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             full, empty, push, pop;
    logic [n-1:0]     wdata;

    assign pop  = !empty && snap.snap_ready;
    assign push = capture && (!full || pop);

`ifdef SNAP_DELTA_EN
    logic [n-1:0] last_cap_q, last_cap_d;

    assign wdata      = q_counter - last_cap_q;
    assign last_cap_d = push ? q_counter : last_cap_q;

    always_ff @(posedge clk) begin
        if (rst_counter) last_cap_q <= '0;
        else             last_cap_q <= last_cap_d;
    end
`else
    assign wdata = q_counter;
`endif

    always_comb begin
        wrap_d = wrap_q;
        ovf_d  = ovf_q;
        if ((q_counter < q_prev_q) && (wrap_q != '1))
            wrap_d = wrap_q + WRAPW'(1);
        if (capture && full && !pop)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_counter) begin
            q_prev_q <= '0;
            wrap_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            q_prev_q <= q_counter;
            wrap_q   <= wrap_d;
            ovf_q    <= ovf_d;
        end
    end

    snap_fifo #(
        .W     (n),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst_counter),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (snap.snap_data),
        .full_o  (full),
        .empty_o (empty),
        .count_o (snap.snap_count)
    );

    assign snap.snap_valid = !empty;
    assign overflow        = ovf_q;
    assign wrap_count      = wrap_q;

endmodule

// File: tb/tb_counter_snapshot_fifo.sv
// Self-checking bench for counter_snapshot_fifo (table vectors + scoreboard).
module tb_counter_snapshot_fifo;
    import counter_snap_pkg::*;

    localparam int N  = SNAP_N;
    localparam int D  = SNAP_DEPTH;
    localparam int WW = SNAP_WRAPW;
    localparam int WMAX = (1 << WW) - 1;

    typedef struct {
        bit           cap;
        bit           rdy;
        logic [N-1:0] q;
        int           e_cnt;
        bit           e_ovf;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_counter = 1'b1;
    logic           capture = 1'b0;
    logic [N-1:0]   q_counter = '0;
    logic           overflow;
    logic [WW-1:0]  wrap_count;

    counter_snapshot_fifo_if #(.N(N), .DEPTH(D)) snap_if ();

    counter_snapshot_fifo #(
        .n     (N),
        .DEPTH (D),
        .WRAPW (WW)
    ) dut (
        .clk         (clk),
        .rst_counter (rst_counter),
        .q_counter   (q_counter),
        .capture     (capture),
        .snap        (snap_if),
        .overflow    (overflow),
        .wrap_count  (wrap_count)
    );

    always #5 clk = ~clk;

    logic [N-1:0] sb [$];
    logic [N-1:0] m_prev, m_last, last_popped;
    int           m_ovf, m_wrap;
    int           n_chk = 0;
    int           n_fail = 0;
    vec_t         vecs [16];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit cap, input bit rdy,
                         input logic [N-1:0] q);
        bit m_pop, m_push, m_full;
        rst_counter = rst;
        capture = cap;
        snap_if.snap_ready = rdy;
        q_counter = q;
        if (rst) begin
            sb.delete();
            m_ovf = 0;
            m_wrap = 0;
            m_prev = '0;
            m_last = '0;
        end else begin
            m_full = (sb.size() == D);
            m_pop  = (sb.size() > 0) && rdy;
            m_push = cap && (!m_full || m_pop);
            if (m_pop) last_popped = sb.pop_front();
            if (m_push) begin
`ifdef SNAP_DELTA_EN
                sb.push_back(q - m_last);
                m_last = q;
`else
                sb.push_back(q);
`endif
            end
            if (cap && !m_push) m_ovf = 1;
            if (q < m_prev && m_wrap < WMAX) m_wrap++;
            m_prev = q;
        end
        @(posedge clk);
        #1;
        chk("count", int'(snap_if.snap_count), sb.size());
        chk("valid", int'(snap_if.snap_valid), int'(sb.size() != 0));
        chk("overflow", int'(overflow), m_ovf);
        chk("wrap_count", int'(wrap_count), m_wrap);
        if (sb.size() != 0)
            chk("data", int'(snap_if.snap_data), int'(sb[0]));
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        snap_if.snap_ready = 1'b0;
        vecs[0]  = '{1, 0, 12'd5,  1, 0};
        vecs[1]  = '{0, 1, 12'd5,  0, 0};
        vecs[2]  = '{0, 1, 12'd5,  0, 0};
        vecs[3]  = '{1, 0, 12'd10, 1, 0};
        vecs[4]  = '{1, 0, 12'd11, 2, 0};
        vecs[5]  = '{1, 0, 12'd12, 3, 0};
        vecs[6]  = '{1, 0, 12'd13, 4, 0};
        vecs[7]  = '{1, 0, 12'd14, 4, 1};
        vecs[8]  = '{0, 0, 12'd14, 4, 1};
        vecs[9]  = '{0, 1, 12'd14, 3, 1};
        vecs[10] = '{0, 1, 12'd14, 2, 1};
        vecs[11] = '{0, 1, 12'd14, 1, 1};
        vecs[12] = '{0, 1, 12'd14, 0, 1};
        vecs[13] = '{1, 1, 12'd15, 1, 1};
        vecs[14] = '{0, 1, 12'd15, 0, 1};
        vecs[15] = '{0, 0, 12'd15, 0, 1};

        do_reset();
        chk("rst count", int'(snap_if.snap_count), 0);
        chk("rst valid", int'(snap_if.snap_valid), 0);
        chk("rst overflow", int'(overflow), 0);
        chk("rst wrap", int'(wrap_count), 0);

        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, vecs[i].cap, vecs[i].rdy, vecs[i].q);
            chk($sformatf("vec%0d count", i), int'(snap_if.snap_count),
                vecs[i].e_cnt);
            chk($sformatf("vec%0d ovf", i), int'(overflow), int'(vecs[i].e_ovf));
        end
        chk("basic first data", int'(vecs[0].q), 5);

        // full FIFO: capture with simultaneous pop is accepted, no overflow
        do_reset();
        for (int i = 0; i < D; i++) cycle(1'b0, 1'b1, 1'b0, N'(10 + i));
        cycle(1'b0, 1'b1, 1'b1, 12'd20);
        chk("full pushpop count", int'(snap_if.snap_count), 4);
        chk("full pushpop ovf", int'(overflow), 0);
        for (int i = 0; i < D; i++) cycle(1'b0, 1'b0, 1'b1, 12'd20);
`ifdef SNAP_DELTA_EN
        chk("full pushpop last", int'(last_popped), 7);
`else
        chk("full pushpop last", int'(last_popped), 20);
`endif

        // wrap detection and saturation
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 12'd4094);
        cycle(1'b0, 1'b0, 1'b0, 12'd4095);
        chk("wrap pre", int'(wrap_count), 0);
        cycle(1'b0, 1'b0, 1'b0, 12'd0);
        chk("wrap once", int'(wrap_count), 1);
        cycle(1'b0, 1'b0, 1'b0, 12'd1);
        chk("wrap hold", int'(wrap_count), 1);
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 12'd100);
            cycle(1'b0, 1'b0, 1'b0, 12'd0);
        end
        chk("wrap sat", int'(wrap_count), 255);

        // reset mid-operation with capture asserted
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 12'd50);
        cycle(1'b0, 1'b1, 1'b0, 12'd40);
        cycle(1'b0, 1'b1, 1'b0, 12'd30);
        cycle(1'b0, 1'b1, 1'b0, 12'd20);
        cycle(1'b0, 1'b1, 1'b0, 12'd10);
        cycle(1'b0, 1'b0, 1'b1, 12'd10);
        chk("mid count", int'(snap_if.snap_count), 3);
        chk("mid ovf", int'(overflow), 1);
        cycle(1'b1, 1'b1, 1'b0, 12'd5);
        chk("mid rst count", int'(snap_if.snap_count), 0);
        chk("mid rst valid", int'(snap_if.snap_valid), 0);
        chk("mid rst ovf", int'(overflow), 0);
        chk("mid rst wrap", int'(wrap_count), 0);
        cycle(1'b0, 1'b0, 1'b0, 12'd0);
        chk("post rst wrap", int'(wrap_count), 0);

`ifdef SNAP_DELTA_EN
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 12'd100);
        cycle(1'b0, 1'b1, 1'b0, 12'd130);
        cycle(1'b0, 1'b0, 1'b1, 12'd130);
        chk("delta first", int'(last_popped), 100);
        cycle(1'b0, 1'b0, 1'b1, 12'd130);
        chk("delta second", int'(last_popped), 30);
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 12'd4090);
        cycle(1'b0, 1'b1, 1'b0, 12'd6);
        cycle(1'b0, 1'b0, 1'b1, 12'd6);
        chk("delta abs", int'(last_popped), 4090);
        cycle(1'b0, 1'b0, 1'b1, 12'd6);
        chk("delta wrap", int'(last_popped), 12);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_snapshot_fifo.md
# counter_snapshot_fifo

Downstream consumer of the up-counter stage. It samples the counter's `q_counter` bus every cycle, counts wrap-arounds, and on a `capture` strobe pushes the current count into a small first-word-fall-through FIFO. The FIFO is drained by a valid/ready interface, so software-facing or logging logic can read timestamps without stalling the counter.

## Interface
- `n`, default 12: width of the counter bus and of the snapshot data.
- `DEPTH`, default 4: FIFO depth in entries. Must be a power of two and ≥ 2.
- `WRAPW`, default 8: width of the wrap counter.

Ports:
- `clk`  input  1: single clock; all logic is on the rising edge.
- `rst_counter`  input  1: reset, synchronous, active-high.
- `q_counter`  input  n: counter value from the upstream counter stage, treated as unsigned.
- `capture`  input  1: snapshot request, sampled each cycle.
- `snap_ready`  input  1: consumer accepts the head entry.
- `snap_valid`  output  1: FIFO is not empty.
- `snap_data`  output  n: head entry.
- `snap_count`  output  $clog2(DEPTH)+1: current occupancy.
- `overflow`  output  1: sticky flag, set when a capture is dropped.
- `wrap_count`  output  WRAPW: number of wraps detected; saturates at all-ones.

## Operation
- `q_prev` register is loaded with `q_counter` every cycle. Its reset value is 0.
- **Wrap detect:** a wrap is flagged when `q_counter < q_prev` (unsigned compare).
  - On a wrap, `wrap_count` increments unless it is already all-ones; at all-ones it holds.
  - Because `q_prev` resets to 0, the first cycle after reset can never flag a wrap.
- **Push:** `push = capture && (!full || pop)`. The pushed word is the `q_counter` value in the same cycle, or the delta value (see Configuration).
- **Pop:** `pop = snap_valid && snap_ready`. `snap_ready` while empty is ignored.
- **Simultaneous push and pop:**
  - When full, both are performed; occupancy stays at DEPTH and no overflow is raised.
  - When empty, there is no bypass: the pushed word appears on the next cycle.
- **Drop:** `capture && full && !pop` drops the word. Occupancy is unchanged and `overflow` is set to 1, held until reset.
- **Pointers:** read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. `snap_count` ranges 0..DEPTH. `full` means `snap_count == DEPTH`; `empty` means `snap_count == 0`.
- `snap_data` shows the head entry whenever `snap_valid` is high. It is don't-care when `snap_valid` is 0; the bench must not check it then.
- **Reset:** applies at the clock edge while `rst_counter` is 1 and takes priority over `capture` and `pop` in the same cycle.
  - Outputs after reset: `snap_valid` 0, `snap_count` 0, `overflow` 0, `wrap_count` 0.
  - Internal state cleared: `q_prev` 0, pointers 0.
  - FIFO contents are discarded. Storage itself needs no reset.

## Timing
- Capture latency: `capture` high at edge k → entry is visible and `snap_valid` is 1 after edge k, i.e. in cycle k+1 (one cycle).
- Pop: the head advances at the edge where `snap_valid && snap_ready`. The next entry, if any, is visible in the following cycle.
- Wrap flag: the `wrap_count` update is visible one cycle after the `q_counter` sample that is lower than the previous one.
- `overflow` rises one cycle after the dropped capture.
- All outputs are registered or derived only from registers. There is no combinational path from `capture` or `snap_ready` to any output.

## Configuration
- **`SNAP_DELTA_EN` defined:**
  - A `last_cap` register (n bits, reset 0) is added.
  - The stored word is `(q_counter - last_cap) mod 2^n`.
  - `last_cap` loads `q_counter` only on an accepted push; a dropped capture leaves it unchanged.
  - The first capture after reset therefore stores the absolute value.
- **`SNAP_DELTA_EN` undefined:** the stored word is the absolute `q_counter` value, and no `last_cap` register exists.

## Structure
- Package `counter_snap_pkg` holds:
  - default constants `SNAP_N = 12`, `SNAP_DEPTH = 4`, `SNAP_WRAPW = 8`;
  - the function computing the pointer width.
- One sub-module, `snap_fifo`: a parameterised synchronous first-word-fall-through FIFO with push/pop/full/empty/count ports. The top level holds the wrap detect, the delta logic and the overflow flag.

## Test plan
- **Basic capture:** after reset, drive `q_counter` 5 and pulse `capture`; `snap_ready` 0. → Next cycle: `snap_valid` 1, `snap_data` 5, `snap_count` 1.
- **Fill and drop:** capture 10, 11, 12, 13, 14 on consecutive cycles with `snap_ready` 0. → `snap_count` 4, `overflow` 1 from the cycle after 14. Draining yields 10, 11, 12, 13.
- **Full with simultaneous push/pop:** FIFO full, `capture` with `q_counter` 20 and `snap_ready` 1 in the same cycle. → `overflow` stays 0, `snap_count` stays 4, and 20 is the last entry drained.
- **Wrap:** drive `q_counter` 4094, 4095, 0, 1 (n = 12). → `wrap_count` goes 0 → 1 exactly once. Forcing 300 wraps → `wrap_count` holds at 255.
- **Reset mid-operation:** with 3 entries held and `overflow` 1, assert `rst_counter` together with `capture`. → Next cycle: `snap_count` 0, `snap_valid` 0, `overflow` 0, `wrap_count` 0.
- **Delta mode (`SNAP_DELTA_EN`):**
  - Capture 100, then 130. → Data drained is 100, then 30.
  - Capture 4090, then 6 (n = 12). → The delta after 4090 is 12.
